// File: rtl/ch_pkg.sv
// rtl/ch_pkg.sv - shared constants and state encoding for the CH table reader
package ch_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_e;

endpackage

// File: rtl/ch_table_reader.sv
// rtl/ch_table_reader.sv - scans 16-bit CH table entries, streams them and tracks the maximum
module ch_table_reader #(
  parameter int WORD_WIDTH = ch_pkg::WORD_WIDTH,
  parameter int MEM_DEPTH  = ch_pkg::MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           base_idx,
  input  logic [4:0]            count,
  output logic [15:0]           mem_index,
  output logic                  mem_wr_en,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [15:0]           out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic [WORD_WIDTH-1:0] best_data,
  output logic [15:0]           best_idx
);

  import ch_pkg::*;

  ch_state_e             state_q, state_d;
  logic [15:0]           ptr_q, ptr_d;
  logic [4:0]            remaining_q, remaining_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]           out_idx_q, out_idx_d;
  logic [WORD_WIDTH-1:0] best_data_q, best_data_d;
  logic [15:0]           best_idx_q, best_idx_d;
  logic                  range_err_q, range_err_d;

  // End of the requested window, widened to 17 bits so a base near 0xFFFF cannot wrap into range
  logic [16:0] scan_end;
  logic        range_bad;

  assign scan_end  = {1'b0, base_idx} + {11'd0, count, 1'b0};
  assign range_bad = (scan_end > 17'(MEM_DEPTH));

  // Next-state, datapath and max-tracker logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    best_data_d = best_data_q;
    best_idx_d  = best_idx_q;
    range_err_d = range_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (range_bad) begin
            // Rejected request: no reads, previous best result stays visible
            range_err_d = 1'b1;
            state_d     = ST_DONE;
          end else if (count == 5'd0) begin
            range_err_d = 1'b0;
            best_data_d = '0;
            best_idx_d  = base_idx;
            state_d     = ST_DONE;
          end else begin
            ptr_d       = base_idx;
            remaining_d = count;
            range_err_d = 1'b0;
            best_data_d = '0;
            best_idx_d  = base_idx;
            state_d     = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        out_data_d = mem_data;
        out_idx_d  = ptr_q;
        // Strict compare so the earliest of equal maxima keeps its index
        if (mem_data > best_data_q) begin
          best_data_d = mem_data;
          best_idx_d  = ptr_q;
        end
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (out_ready) begin
          if (remaining_q == 5'd1) begin
            state_d = ST_DONE;
          end else begin
            ptr_d       = ptr_q + 16'd2;
            remaining_d = remaining_q - 5'd1;
            state_d     = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      best_data_q <= '0;
      best_idx_q  <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      best_data_q <= best_data_d;
      best_idx_q  <= best_idx_d;
      range_err_q <= range_err_d;
    end
  end

  assign mem_index = ptr_q;
  assign mem_wr_en = 1'b0;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign range_err = range_err_q;
  assign best_data = best_data_q;
  assign best_idx  = best_idx_q;

endmodule

// File: doc/ch_table_reader.md
CH_TABLE_READER -- requirements
Module: ch_table_reader

Interface
REQ-001 Parameter WORD_WIDTH, default 16: word width of CH memory bank entries.
REQ-002 Parameter MEM_DEPTH, default 32: byte depth of CH memory bank.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle scan request; sampled only in IDLE.
REQ-006 base_idx  input  16  byte index of first entry; may be odd.
REQ-007 count  input  5  number of 16-bit entries to read, 0..16.
REQ-008 mem_index  output  16  byte index driven to the memory bank.
REQ-009 mem_wr_en  output  1  memory write enable; constant 0.
REQ-010 mem_data  input  16  combinational read data, {mem[index], mem[index+1]}.
REQ-011 out_data  output  16  streamed entry value.
REQ-012 out_idx  output  16  byte index of out_data.
REQ-013 out_valid  output  1  out_data/out_idx valid.
REQ-014 out_ready  input  1  downstream accepts the current entry.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at scan end.
REQ-017 range_err  output  1  scan rejected for out-of-range request; held until next accepted start.
REQ-018 best_data  output  16  maximum entry value from last scan.
REQ-019 best_idx  output  16  byte index of best_data.

Function
REQ-020 FSM states: IDLE, FETCH, HOLD, DONE.
REQ-021 IDLE: on start, when base_idx + 2*count > MEM_DEPTH, set range_err, go DONE, no reads.
REQ-022 IDLE: on start with count=0, go DONE; best_data=0; best_idx=base_idx.
REQ-023 IDLE: on any other start, latch ptr=base_idx and remaining=count, clear range_err, set best_data=0 and best_idx=base_idx, go FETCH.
REQ-024 FETCH: mem_index=ptr; capture mem_data into out_data and ptr into out_idx; go HOLD.
REQ-025 FETCH: if mem_data > best_data (unsigned, strict), update best_data and best_idx; on ties the first entry wins.
REQ-026 HOLD: out_valid=1, out_data and out_idx held stable until out_ready=1.
REQ-027 HOLD handshake: when remaining=1, go DONE; otherwise ptr+=2, remaining-=1, go FETCH.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 Latency: start in cycle N gives out_valid in cycle N+2; throughput is 1 entry per 2 cycles with out_ready tied high.
REQ-030 start outside IDLE is ignored; parameters are not re-latched.
REQ-031 best_data, best_idx and range_err hold their values after DONE until the next accepted start.
REQ-032 ptr arithmetic is 16-bit; the range check is evaluated in 17 bits so no wrap passes.
REQ-033 mem_index=ptr in every state; mem_wr_en=0 always.

Reset
REQ-034 rst=1 at a clock edge forces IDLE from any state, including mid-scan with out_valid high.
REQ-035 Reset values: out_valid=0, busy=0, done=0, range_err=0, out_data=0, out_idx=0, best_data=0, best_idx=0, ptr=0, remaining=0.
REQ-036 The first cycle after reset deassertion accepts start.

Structure
REQ-037 A shared package ch_pkg holds WORD_WIDTH, MEM_DEPTH and the state encoding.
REQ-038 Single module, no sub-modules; the max-tracker is inline logic.
REQ-039 Bench connects the block directly to the existing CH memory bank instance.

Verification
REQ-040 Preload memory bytes 0..7 = 00 05 01 20 00 07 01 20; start base=0, count=4, out_ready=1 -> outputs 0x0005@0, 0x0120@2, 0x0007@4, 0x0120@6; best_data=0x0120, best_idx=2; done in cycle 9.
REQ-041 Backpressure: out_ready low for 3 cycles in first HOLD -> out_valid stays high, out_data=0x0005 stable, no index advance.
REQ-042 base=28, count=3 -> range_err=1, done next cycle, no out_valid; base=28, count=2 -> 2 entries, range_err=0.
REQ-043 count=0, base=10 -> done in cycle N+1, best_data=0, best_idx=10.
REQ-044 rst asserted in HOLD of entry 2 -> next cycle all outputs at reset values; new start works immediately.
REQ-045 start pulsed while busy -> ignored; the scan completes with the original base and count.
